// File: rtl/prefix_sum_if.sv
// Handshake and data bundle between the final prefix layer, the sum/flag stage and its consumer.
// The slave modport is the stage itself; the master modport is the surrounding environment.
interface prefix_sum_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] g;
    logic [31:0] p;
    logic        c0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
    logic [15:0] ovf_cnt;

    modport master (
        output in_valid, g, p, c0, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero, neg, ovf_cnt
    );

    modport slave (
        input  in_valid, g, p, c0, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero, neg, ovf_cnt
    );
endinterface

// File: rtl/prefix_sum_stage.sv
// Sum/flag stage after the last prefix layer, buffered by a 2-entry valid/ready skid buffer.
// Optional feature macro: PSUM_OVF_COUNT_EN builds a saturating 16-bit overflow event counter.
module prefix_sum_stage (
    input  logic         clk,
    input  logic         rst,
    prefix_sum_if.slave  bus
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t      state_reg, state_next;
    logic [35:0] out_reg, skid_reg;
    logic [35:0] beat_word;
    logic [35:0] out_view;
    logic [31:0] carry_into;
    logic [31:0] sum_beat;
    logic        beat_ovf;
    logic        in_ready_int, out_valid_int;
    logic        push, pop;
    logic        load_out, out_from_skid, load_skid;

    // Carry into bit i is the carry out of bit i-1; bit 0 takes the adder carry-in.
    assign carry_into = {bus.g[30:0], bus.c0};

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_sum_bit
            assign sum_beat[gi] = bus.p[gi] ^ carry_into[gi];
        end
    endgenerate

    assign beat_ovf  = bus.g[31] ^ bus.g[30];
    // Result word layout: {cout, ovf, zero, neg, sum[31:0]}
    assign beat_word = {bus.g[31], beat_ovf, (sum_beat == 32'h0), sum_beat[31], sum_beat};

    // Handshake depends on registered state only, so out_ready never reaches in_ready.
    assign in_ready_int  = (state_reg != FULL);
    assign out_valid_int = (state_reg != EMPTY);
    assign push          = bus.in_valid & in_ready_int;
    assign pop           = out_valid_int & bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        load_out      = 1'b0;
        out_from_skid = 1'b0;
        load_skid     = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (push) begin
                    state_next = ONE;
                    load_out   = 1'b1;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    state_next = FULL;
                    load_skid  = 1'b1;
                end else if (push && pop) begin
                    load_out   = 1'b1;
                end else if (pop) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_next    = ONE;
                    load_out      = 1'b1;
                    out_from_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // Data registers carry no reset; the state register alone decides whether they are meaningful.
    always_ff @(posedge clk) begin
        if (load_out) begin
            out_reg <= out_from_skid ? skid_reg : beat_word;
        end
        if (load_skid) begin
            skid_reg <= beat_word;
        end
    end

    // Outputs read zero whenever nothing is held, including immediately on reset.
    assign out_view      = out_valid_int ? out_reg : 36'h0;
    assign bus.sum       = out_view[31:0];
    assign bus.neg       = out_view[32];
    assign bus.zero      = out_view[33];
    assign bus.ovf       = out_view[34];
    assign bus.cout      = out_view[35];
    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_int;

`ifdef PSUM_OVF_COUNT_EN
    logic [15:0] ovf_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt_reg <= 16'h0000;
        end else if (push && beat_ovf && (ovf_cnt_reg != 16'hFFFF)) begin
            ovf_cnt_reg <= ovf_cnt_reg + 16'h0001;
        end
    end

    assign bus.ovf_cnt = ovf_cnt_reg;
`else
    assign bus.ovf_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_prefix_sum_stage.sv
// Self-checking bench for prefix_sum_stage: directed scenarios plus randomized traffic
// compared against an arithmetic reference model (x + y + cin) and a FIFO of expected results.
module tb_prefix_sum_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prefix_sum_if bus ();

    prefix_sum_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] s;
        logic        co;
        logic        ov;
    } res_t;

    int          checks  = 0;
    int          errors  = 0;
    bit          verbose = 1'b1;
    res_t        model_q[$];
    int unsigned exp_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Carry out of bit i of x + y + ci, from a plain addition of the low i+1 bits.
    function automatic logic [31:0] carries(input logic [31:0] x, input logic [31:0] y, input logic ci);
        logic [31:0] c;
        logic [63:0] m;
        logic [63:0] t;
        for (int i = 0; i < 32; i++) begin
            m    = (64'd1 << (i + 1)) - 64'd1;
            t    = ({32'h0, x} & m) + ({32'h0, y} & m) + {63'h0, ci};
            c[i] = t[i + 1];
        end
        return c;
    endfunction

    function automatic res_t reference(input logic [31:0] x, input logic [31:0] y, input logic ci);
        res_t        r;
        logic [32:0] s;
        s    = {1'b0, x} + {1'b0, y} + {32'h0, ci};
        r.s  = s[31:0];
        r.co = s[32];
        r.ov = (x[31] == y[31]) && (s[31] != x[31]);
        return r;
    endfunction

    function automatic logic [15:0] exp_cnt_out();
`ifdef PSUM_OVF_COUNT_EN
        return exp_cnt[15:0];
`else
        return 16'h0000;
`endif
    endfunction

    task automatic check_outputs();
        res_t h;
        bit   has = (model_q.size() > 0);
        check("out_valid", 64'(bus.out_valid), 64'(has));
        check("in_ready", 64'(bus.in_ready), 64'(model_q.size() < 2));
        if (has) begin
            h = model_q[0];
            check("sum", 64'(bus.sum), 64'(h.s));
            check("cout", 64'(bus.cout), 64'(h.co));
            check("ovf", 64'(bus.ovf), 64'(h.ov));
            check("zero", 64'(bus.zero), 64'(h.s == 32'h0));
            check("neg", 64'(bus.neg), 64'(h.s[31]));
        end else begin
            check("idle_sum", 64'(bus.sum), 64'h0);
            check("idle_flags", 64'({bus.cout, bus.ovf, bus.zero, bus.neg}), 64'h0);
        end
        check("ovf_cnt", 64'(bus.ovf_cnt), 64'(exp_cnt_out()));
    endtask

    // One cycle: check outputs at negedge, drive a beat, update the model at the next posedge.
    task automatic step(input bit v, input logic [31:0] x, input logic [31:0] y, input logic ci, input bit ordy);
        bit   do_push, do_pop;
        res_t r;
        @(negedge clk);
        check_outputs();
        bus.in_valid  = v;
        bus.p         = x ^ y;
        bus.g         = carries(x, y, ci);
        bus.c0        = ci;
        bus.out_ready = ordy;
        r       = reference(x, y, ci);
        do_push = v && (model_q.size() < 2);
        do_pop  = ordy && (model_q.size() > 0);
        @(posedge clk);
        if (do_pop) begin
            if (verbose) $display("t=%0t pop  sum=%h", $time, model_q[0].s);
            void'(model_q.pop_front());
        end
        if (do_push) begin
            model_q.push_back(r);
            if (r.ov && exp_cnt < 32'h0000_FFFF) exp_cnt++;
            if (verbose) $display("t=%0t push x=%h y=%h c0=%0d sum=%h", $time, x, y, ci, r.s);
        end
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, 32'h0, 32'h0, 1'b0, ordy);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.g         = 32'h0;
        bus.p         = 32'h0;
        bus.c0        = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'h0);
        check("rst_in_ready", 64'(bus.in_ready), 64'h1);
        check("rst_sum", 64'(bus.sum), 64'h0);
        check("rst_ovf_cnt", 64'(bus.ovf_cnt), 64'h0);
        rst = 1'b0;

        // Zero-carry sum
        step(1'b1, 32'h0000_00FF, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("zc_sum", 64'(bus.sum), 64'h0000_00FF);
        check("zc_flags", 64'({bus.cout, bus.zero, bus.neg}), 64'h0);
        idle(1'b1);

        // Carry chain 0x7FFFFFFF + 1
        step(1'b1, 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        check("cc_sum", 64'(bus.sum), 64'h8000_0000);
        check("cc_ovf_neg_cout", 64'({bus.ovf, bus.neg, bus.cout}), 64'b110);
`ifdef PSUM_OVF_COUNT_EN
        check("cc_ovf_cnt", 64'(bus.ovf_cnt), 64'h1);
`endif
        idle(1'b1);

        // Backpressure: A then B with out_ready low
        step(1'b1, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
        step(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        step(1'b1, 32'h1234_5678, 32'h1, 1'b0, 1'b0);
        @(negedge clk);
        check("bp_in_ready", 64'(bus.in_ready), 64'h0);
        check("bp_head", 64'(bus.sum), 64'h3333_3333);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);

        // Simultaneous push/pop from ONE
        step(1'b1, 32'h0000_0010, 32'h0000_0001, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'(i * 3), 32'(i * 5 + 7), 1'(i % 2), 1'b1);
        end
        idle(1'b1);
        idle(1'b0);

        // Mid-operation reset while FULL
        step(1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0);
        step(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b0);
        @(negedge clk);
        check("pre_rst_full", 64'(bus.in_ready), 64'h0);
        rst = 1'b1;
        #1;
        check("mrst_out_valid", 64'(bus.out_valid), 64'h0);
        check("mrst_in_ready", 64'(bus.in_ready), 64'h1);
        check("mrst_sum", 64'(bus.sum), 64'h0);
        check("mrst_ovf_cnt", 64'(bus.ovf_cnt), 64'h0);
        model_q.delete();
        exp_cnt = 0;
        #1;
        rst = 1'b0;
        step(1'b1, 32'h0000_0100, 32'h0000_0023, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // Randomized traffic
        verbose = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 4) != 0, $urandom, $urandom, 1'($urandom), ($urandom % 3) != 0);
        end
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);

`ifdef PSUM_OVF_COUNT_EN
        // Counter saturation
        for (int i = 0; i < 65540; i++) begin
            step(1'b1, 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b1);
        end
        idle(1'b1);
        @(negedge clk);
        check("sat_ovf_cnt", 64'(bus.ovf_cnt), 64'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/prefix_sum_stage.md
# prefix_sum_stage

Registered sum/flag stage for the 32-bit prefix adder, directly downstream of the final prefix layer. It consumes the per-bit carries produced by that layer plus the bitwise propagate (half-sum) vector and carry-in, forms the 32-bit sum and ALU flags, and presents them through a 2-entry valid/ready skid buffer so the processor's execute stage can stall without losing results.

## Interface
Parameters:
- none; width fixed at 32.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  carry/propagate vectors valid this cycle.
- in_ready  output  1  stage can accept; high when the skid entry is empty.
- g  input  32  carry out of bit i from the last prefix layer; c0 already folded in.
- p  input  32  propagate/half-sum, p[i] = x[i] ^ y[i].
- c0  input  1  adder carry-in.
- out_valid  output  1  result registers hold a valid result.
- out_ready  input  1  consumer accepts the result this cycle.
- sum  output  32  sum result.
- cout  output  1  carry out, g[31].
- ovf  output  1  signed overflow, g[31] ^ g[30].
- zero  output  1  sum == 0.
- neg  output  1  sum[31].
- ovf_cnt  output  16  overflow event count (see Configuration).

## Operation
- Sum: sum[0] = p[0] ^ c0; sum[i] = p[i] ^ g[i-1] for i = 1..31. Flags are computed from the same input beat and stored alongside sum in a 36-bit result word.
- Storage: output register (OUT) drives the outputs; skid register (SKID) holds one extra result.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- States:
  - EMPTY: out_valid=0, in_ready=1. push -> ONE, OUT <= new.
  - ONE: out_valid=1, in_ready=1. push & !pop -> FULL, SKID <= new. push & pop -> ONE, OUT <= new. !push & pop -> EMPTY. Neither -> hold.
  - FULL: out_valid=1, in_ready=0. pop -> ONE, OUT <= SKID. No push possible.
- in_ready is a function of registered state only; there is no combinational path from out_ready to in_ready.
- Outputs are stable while out_valid=1 and out_ready=0.
- Data registers need no reset; the state register does. In EMPTY, sum and flags read 0; they are zeroed on reset.

## Timing
- Latency: a beat pushed in cycle N appears on outputs in cycle N+1 when the buffer was EMPTY, or when it was ONE with a simultaneous pop.
- Throughput: 1 result/cycle while out_ready is held high.
- Reset, including mid-operation: state=EMPTY, out_valid=0, in_ready=1, sum=0, cout=ovf=zero=neg=0, ovf_cnt=0. Buffered results are discarded.
- Order is preserved: SKID always drains before any newer beat.
- in_valid while in_ready=0: the input is ignored; the upstream must hold it.

## Configuration
- PSUM_OVF_COUNT_EN defined: ovf_cnt is a 16-bit saturating counter.
  - Increments on each push whose computed ovf is 1.
  - Holds at 16'hFFFF.
  - Cleared only by rst.
- Not defined: ovf_cnt is tied to 16'h0000 and no counter logic is built.

## Test plan
- Zero-carry sum: after reset, out_valid=0, in_ready=1. Push p=32'h0000_00FF, g=0, c0=0 -> next cycle sum=32'h0000_00FF, cout=0, zero=0, neg=0.
- Carry chain (0x7FFFFFFF+1): push p=32'h7FFF_FFFF, c0=1, g=32'h7FFF_FFFF -> sum=32'h8000_0000, ovf=1, neg=1, cout=0. With PSUM_OVF_COUNT_EN defined, ovf_cnt=1.
- Backpressure: hold out_ready=0 and push A then B -> in_ready=0 after B. Assert out_ready -> A then B on consecutive cycles, and in_ready returns high the cycle after A pops.
- Simultaneous push/pop: in ONE with out_ready=1, push every cycle for 8 cycles -> 8 results in order, state never FULL.
- Mid-operation reset: assert rst while FULL -> same cycle out_valid=0, in_ready=1, sum=0, ovf_cnt=0. The following push appears alone.
- Counter saturation (PSUM_OVF_COUNT_EN): 65540 overflowing pushes -> ovf_cnt=16'hFFFF, no wrap.
